// File: rtl/intersection_scheduler.sv
// Round-robin right-of-way scheduler for one intersection: GREEN -> YELLOW -> ALL_RED,
// with approach 0 (home road) resting green when nobody else is waiting.
module intersection_scheduler #(
  parameter int N_APPROACH   = 4,
  parameter int CNT_W        = 8,
  parameter int MIN_GREEN    = 4,
  parameter int MAX_GREEN    = 10,
  parameter int YELLOW_TICKS = 2,
  parameter int RED_TICKS    = 1
) (
  input  logic                    clk,
  input  logic                    clear_n,
  input  logic                    tick,
  input  logic [N_APPROACH-1:0]   req,
  output logic [2*N_APPROACH-1:0] light,
  output logic [N_APPROACH-1:0]   grant,
  output logic [1:0]              phase
);

  localparam int OW = (N_APPROACH > 1) ? $clog2(N_APPROACH) : 1;
  localparam logic [CNT_W:0] MIN_E    = (CNT_W+1)'(MIN_GREEN);
  localparam logic [CNT_W:0] MAX_E    = (CNT_W+1)'(MAX_GREEN);
  localparam logic [CNT_W:0] YELLOW_E = (CNT_W+1)'(YELLOW_TICKS);
  localparam logic [CNT_W:0] RED_E    = (CNT_W+1)'(RED_TICKS);

  typedef enum logic [1:0] {
    ALL_RED = 2'd0,
    GREEN   = 2'd1,
    YELLOW  = 2'd2
  } state_t;

  state_t                  state, state_nx;
  logic [OW-1:0]           owner, owner_nx, pick;
  logic [CNT_W-1:0]        cnt, cnt_nx;
  logic [CNT_W:0]          elapsed;
  logic [N_APPROACH-1:0]   owner_oh, grant_nx;
  logic [2*N_APPROACH-1:0] light_nx;
  logic                    other;

  // Next owner: scanning from the farthest candidate back to owner+1 leaves the
  // nearest requester in pick; owner itself is the last candidate, home road if idle.
  always_comb begin
    int idx;
    pick = '0;
    idx  = 0;
    for (int k = N_APPROACH; k >= 1; k--) begin
      idx = (int'(owner) + k) % N_APPROACH;
      if (req[idx]) pick = OW'(idx);
    end
  end

  assign owner_oh = N_APPROACH'(1) << owner;
  assign other    = |(req & ~owner_oh);
  assign elapsed  = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    cnt_nx   = cnt;
    if (tick) begin
      unique case (state)
        ALL_RED: begin
          if (elapsed >= RED_E) begin
            state_nx = GREEN;
            owner_nx = pick;
            cnt_nx   = '0;
          end else begin
            cnt_nx = elapsed[CNT_W-1:0];
          end
        end
        GREEN: begin
          if (other && ((elapsed >= MIN_E && !req[owner]) || elapsed >= MAX_E)) begin
            state_nx = YELLOW;
            cnt_nx   = '0;
          end else if (elapsed >= MAX_E) begin
            cnt_nx = MAX_E[CNT_W-1:0];
          end else begin
            cnt_nx = elapsed[CNT_W-1:0];
          end
        end
        YELLOW: begin
          if (elapsed >= YELLOW_E) begin
            state_nx = ALL_RED;
            cnt_nx   = '0;
          end else begin
            cnt_nx = elapsed[CNT_W-1:0];
          end
        end
        default: begin
          state_nx = ALL_RED;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they register on the same edge.
  always_comb begin
    grant_nx = '0;
    light_nx = '0;
    for (int i = 0; i < N_APPROACH; i++) begin
      if (OW'(i) == owner_nx) begin
        if (state_nx == GREEN) begin
          grant_nx[i]        = 1'b1;
          light_nx[2*i +: 2] = 2'b10;
        end else if (state_nx == YELLOW) begin
          grant_nx[i]        = 1'b1;
          light_nx[2*i +: 2] = 2'b01;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state <= ALL_RED;
      owner <= '0;
      cnt   <= '0;
      grant <= '0;
      light <= '0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      cnt   <= cnt_nx;
      grant <= grant_nx;
      light <= light_nx;
    end
  end

  assign phase = state;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Scoreboard bench: the driver steps a tick-level reference model and queues the expected
// outputs; a monitor pops and compares after every clock edge.
module tb_intersection_scheduler;

  localparam int N          = 4;
  localparam int MIN_GREEN  = 4;
  localparam int MAX_GREEN  = 10;
  localparam int YELLOW_T   = 2;
  localparam int RED_T      = 1;

  typedef struct packed {
    logic [1:0]     phase;
    logic [N-1:0]   grant;
    logic [2*N-1:0] light;
  } exp_t;

  logic           clk = 1'b0;
  logic           clear_n = 1'b0;
  logic           tick = 1'b0;
  logic [N-1:0]   req = '0;
  logic [2*N-1:0] light;
  logic [N-1:0]   grant;
  logic [1:0]     phase;

  int checks = 0;
  int failures = 0;

  exp_t exp_q[$];

  // reference model state: phase 0 all-red, 1 green, 2 yellow; ticks spent in phase
  int m_phase = 0;
  int m_owner = 0;
  int m_ticks = 0;

  intersection_scheduler #(
    .N_APPROACH(N), .CNT_W(8), .MIN_GREEN(MIN_GREEN), .MAX_GREEN(MAX_GREEN),
    .YELLOW_TICKS(YELLOW_T), .RED_TICKS(RED_T)
  ) dut (
    .clk(clk), .clear_n(clear_n), .tick(tick), .req(req),
    .light(light), .grant(grant), .phase(phase)
  );

  always #5 clk = ~clk;

  function automatic int next_owner(input int cur, input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      if (r[(cur + k) % N]) return (cur + k) % N;
    end
    return 0;
  endfunction

  function automatic exp_t model_outputs();
    exp_t e;
    e = '0;
    e.phase = m_phase[1:0];
    if (m_phase != 0) begin
      e.grant[m_owner] = 1'b1;
      e.light[2*m_owner +: 2] = (m_phase == 1) ? 2'b10 : 2'b01;
    end
    return e;
  endfunction

  task automatic model_tick(input logic [N-1:0] r);
    int  done;
    bit  waiting;
    done = m_ticks + 1;
    case (m_phase)
      0: if (done >= RED_T) begin m_phase = 1; m_owner = next_owner(m_owner, r); m_ticks = 0; end
         else m_ticks = done;
      1: begin
        waiting = 0;
        for (int j = 0; j < N; j++) if (j != m_owner && r[j]) waiting = 1;
        if (waiting && ((done >= MIN_GREEN && !r[m_owner]) || done >= MAX_GREEN)) begin
          m_phase = 2; m_ticks = 0;
        end else begin
          m_ticks = (done > MAX_GREEN) ? MAX_GREEN : done;
        end
      end
      default: if (done >= YELLOW_T) begin m_phase = 0; m_ticks = 0; end
               else m_ticks = done;
    endcase
  endtask

  task automatic apply_stimulus(input logic t, input logic [N-1:0] r);
    @(negedge clk);
    clear_n = 1'b1;
    tick = t;
    req = r;
    if (t) model_tick(r);
    exp_q.push_back(model_outputs());
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_n = 1'b0;
    m_phase = 0; m_owner = 0; m_ticks = 0;
    #1;
    checks++;
    if (phase !== 2'd0 || grant !== '0 || light !== '0) begin
      failures++;
      $display("[TB] FAIL async_reset: phase=%0d grant=%b light=%b, required phase=0 grant=0 light=0",
               phase, grant, light);
    end
  endtask

  task automatic check_output(input exp_t e);
    checks++;
    if (phase !== e.phase || grant !== e.grant || light !== e.light) begin
      failures++;
      $display("[TB] FAIL outputs @%0t: phase=%0d grant=%b light=%b, required phase=%0d grant=%b light=%b",
               $time, phase, grant, light, e.phase, e.grant, e.light);
    end
    checks++;
    if (!$onehot0(grant)) begin
      failures++;
      $display("[TB] FAIL grant_onehot @%0t: grant=%b, required at most one bit set", $time, grant);
    end
  endtask

  // Monitor: outputs are valid after every edge for which the driver queued a prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output(e);
      end
    end
  end

  initial begin
    logic [N-1:0] r;
    bit reached;

    // home road rests green with no demand
    do_reset();
    repeat (50) apply_stimulus(1'b1, 4'b0000);

    // gap-out of approach 0 toward approach 2, which then rests
    do_reset();
    repeat (30) apply_stimulus(1'b1, 4'b0100);

    // both 0 and 2 waiting: max-out alternation
    do_reset();
    repeat (60) apply_stimulus(1'b1, 4'b0101);

    // owner 1, then 3 and 0 alternate; 1 never returns
    do_reset();
    repeat (3) apply_stimulus(1'b1, 4'b0010);
    repeat (60) apply_stimulus(1'b1, 4'b1001);

    // slow timebase: one tick in four cycles
    do_reset();
    for (int c = 0; c < 120; c++) apply_stimulus(c % 4 == 3, 4'b0100);

    // reset in the middle of approach 2's yellow, then restart
    do_reset();
    reached = 0;
    for (int c = 0; c < 300 && !reached; c++) begin
      apply_stimulus(1'b1, 4'b0101);
      if (m_phase == 2 && m_owner == 2) reached = 1;
    end
    checks++;
    if (!reached) begin
      failures++;
      $display("[TB] FAIL reach_yellow2: reached=0, required yellow on approach 2 within 300 cycles");
    end
    do_reset();
    repeat (30) apply_stimulus(1'b1, 4'b0100);

    // randomized traffic with sticky sensors and a jittery timebase
    r = 4'b0000;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 249) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 7) == 0) r = N'($urandom);
        apply_stimulus($urandom_range(0, 3) != 0, r);
      end
    end

    @(posedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
